dfp_arbiter: RTL and testbench



---
 rtl/dfp_arbiter.sv | 72 +++++++
 tb/tb_dfp_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dfp_arbiter.sv
// dfp_arbiter: shares one 256-bit memory port between icache and dcache, one whole transaction at a time
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   i_dfp_addr/read/write/wdata icache request in; i_dfp_rdata/resp out
//   d_dfp_addr/read/write/wdata dcache request in; d_dfp_rdata/resp out
//   dfp_addr/read/write/wdata   memory request out; dfp_rdata/resp in
// Option: define DFP_ARB_ROUND_ROBIN_EN so simultaneous requests alternate,
//   starting with dcache; otherwise dcache always wins a tie.
module dfp_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_dfp_addr,
  input  logic                  i_dfp_read,
  input  logic                  i_dfp_write,
  input  logic [LINE_WIDTH-1:0] i_dfp_wdata,
  output logic [LINE_WIDTH-1:0] i_dfp_rdata,
  output logic                  i_dfp_resp,
  input  logic [ADDR_WIDTH-1:0] d_dfp_addr,
  input  logic                  d_dfp_read,
  input  logic                  d_dfp_write,
  input  logic [LINE_WIDTH-1:0] d_dfp_wdata,
  output logic [LINE_WIDTH-1:0] d_dfp_rdata,
  output logic                  d_dfp_resp,
  output logic [ADDR_WIDTH-1:0] dfp_addr,
  output logic                  dfp_read,
  output logic                  dfp_write,
  output logic [LINE_WIDTH-1:0] dfp_wdata,
  input  logic [LINE_WIDTH-1:0] dfp_rdata,
  input  logic                  dfp_resp
);
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;
  state_t state_q, state_d;
  logic req_i, req_d, tie_d, gnt_i, gnt_d;
  assign req_i = i_dfp_read | i_dfp_write;
  assign req_d = d_dfp_read | d_dfp_write;
  assign gnt_i = state_q == GRANT_I;
  assign gnt_d = state_q == GRANT_D;
`ifdef DFP_ARB_ROUND_ROBIN_EN
  // last_d_q is 1 when dcache owned the most recently completed grant; reset means icache
  logic last_d_q, last_d_d;
  assign tie_d = ~last_d_q;
  assign last_d_d = (dfp_resp & (gnt_i | gnt_d)) ? gnt_d : last_d_q;
  always_ff @(posedge clk) begin
    if (rst) last_d_q <= 1'b0;
    else     last_d_q <= last_d_d;
  end
`else
  assign tie_d = 1'b1;
`endif
  // A grant lasts until dfp_resp; any other encoding falls back to arbitration
  always_comb begin
    state_d = (gnt_i | gnt_d) ? (dfp_resp ? IDLE : state_q)
            : (req_d & (tie_d | ~req_i)) ? GRANT_D
            : req_i ? GRANT_I : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  // Downstream mirrors the owner; a read+write request is issued as a write
  assign dfp_addr    = gnt_i ? i_dfp_addr  : gnt_d ? d_dfp_addr  : '0;
  assign dfp_wdata   = gnt_i ? i_dfp_wdata : gnt_d ? d_dfp_wdata : '0;
  assign dfp_write   = gnt_i ? i_dfp_write : gnt_d & d_dfp_write;
  assign dfp_read    = gnt_i ? (i_dfp_read & ~i_dfp_write) : (gnt_d & d_dfp_read & ~d_dfp_write);
  assign i_dfp_resp  = gnt_i & dfp_resp;
  assign d_dfp_resp  = gnt_d & dfp_resp;
  assign i_dfp_rdata = gnt_i ? dfp_rdata : '0;
  assign d_dfp_rdata = gnt_d ? dfp_rdata : '0;
endmodule

// File: tb/tb_dfp_arbiter.sv
// tb_dfp_arbiter: self-checking bench for dfp_arbiter
module tb_dfp_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam logic [AW-1:0] IA = 32'h0000_1040;
  localparam logic [AW-1:0] DA = 32'h0000_2000;
  localparam logic [LW-1:0] IW = {8{32'h1111_2222}};
  localparam logic [LW-1:0] DW = {8{32'hDEAD_BEEF}};
  localparam logic [LW-1:0] MR = {8{32'hCAFE_F00D}};
  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] i_dfp_addr, d_dfp_addr, dfp_addr;
  logic i_dfp_read, i_dfp_write, d_dfp_read, d_dfp_write;
  logic dfp_read, dfp_write, dfp_resp, i_dfp_resp, d_dfp_resp;
  logic [LW-1:0] i_dfp_wdata, d_dfp_wdata, dfp_wdata, dfp_rdata, i_dfp_rdata, d_dfp_rdata;
  int checks = 0;
  int errors = 0;
  int own = 0;
  int last = 1;
  string phase = "init";
  int resp_log[$];
  typedef struct {
    bit ir, iw, dr, dw, r;
    int own;
  } vec_t;
  vec_t tbl[11];

  always #5 clk = ~clk;

  dfp_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .i_dfp_addr(i_dfp_addr), .i_dfp_read(i_dfp_read), .i_dfp_write(i_dfp_write),
    .i_dfp_wdata(i_dfp_wdata), .i_dfp_rdata(i_dfp_rdata), .i_dfp_resp(i_dfp_resp),
    .d_dfp_addr(d_dfp_addr), .d_dfp_read(d_dfp_read), .d_dfp_write(d_dfp_write),
    .d_dfp_wdata(d_dfp_wdata), .d_dfp_rdata(d_dfp_rdata), .d_dfp_resp(d_dfp_resp),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp)
  );

  always @(negedge clk) begin
    if (i_dfp_resp) resp_log.push_back(1);
    if (d_dfp_resp) resp_log.push_back(2);
  end

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Expected port behaviour given who owns the memory port (0 none, 1 icache, 2 dcache)
  task automatic check_outs(input int o);
    chk({phase, ":addr"}, dfp_addr, o == 1 ? i_dfp_addr : o == 2 ? d_dfp_addr : '0);
    chk({phase, ":wdata"}, dfp_wdata, o == 1 ? i_dfp_wdata : o == 2 ? d_dfp_wdata : '0);
    chk({phase, ":write"}, dfp_write, o == 1 ? i_dfp_write : o == 2 ? d_dfp_write : 1'b0);
    chk({phase, ":read"}, dfp_read, o == 1 ? (i_dfp_read && !i_dfp_write) : o == 2 ? (d_dfp_read && !d_dfp_write) : 1'b0);
    chk({phase, ":i_resp"}, i_dfp_resp, o == 1 && dfp_resp);
    chk({phase, ":d_resp"}, d_dfp_resp, o == 2 && dfp_resp);
    chk({phase, ":i_rdata"}, i_dfp_rdata, o == 1 ? dfp_rdata : '0);
    chk({phase, ":d_rdata"}, d_dfp_rdata, o == 2 ? dfp_rdata : '0);
  endtask

  function automatic int tie_winner();
`ifdef DFP_ARB_ROUND_ROBIN_EN
    return last == 2 ? 1 : 2;
`else
    return 2;
`endif
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // One cycle: drive, check against expected owner (exp_own < 0 uses the model), advance model
  task automatic tick(input bit ir, input bit iw, input bit dr, input bit dw, input bit r, input int exp_own);
    i_dfp_read = ir; i_dfp_write = iw; d_dfp_read = dr; d_dfp_write = dw; dfp_resp = r;
    @(negedge clk);
    check_outs(exp_own >= 0 ? exp_own : own);
    if (own == 0) own = ((ir | iw) && (dr | dw)) ? tie_winner() : (dr | dw) ? 2 : (ir | iw) ? 1 : 0;
    else if (r) begin last = own; own = 0; end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit pi, pd, r;
    int ik, dk, o, w;
    int exp_order[6];
    exp_order = '{2, 1, 2, 1, 2, 1};
    i_dfp_addr = IA; d_dfp_addr = DA; i_dfp_wdata = IW; d_dfp_wdata = DW; dfp_rdata = MR;
    rst = 1'b1;
    i_dfp_read = 1; i_dfp_write = 0; d_dfp_read = 1; d_dfp_write = 0; dfp_resp = 1;
    @(posedge clk); #1;
    phase = "reset";
    @(negedge clk);
    check_outs(0);
    @(posedge clk); #1;
    rst = 1'b0;
    i_dfp_read = 0; d_dfp_read = 0; dfp_resp = 0;
    own = 0; last = 1;

    tbl[0]  = '{1, 0, 1, 0, 1, 0};
    tbl[1]  = '{1, 0, 1, 0, 0, 2};
    tbl[2]  = '{1, 0, 1, 0, 1, 2};
    tbl[3]  = '{1, 0, 0, 0, 0, 0};
    tbl[4]  = '{1, 1, 0, 0, 0, 1};
    tbl[5]  = '{0, 0, 1, 0, 0, 1};
    tbl[6]  = '{1, 0, 1, 0, 1, 1};
    tbl[7]  = '{0, 0, 1, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 1, 1, 2};
    tbl[9]  = '{0, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 1, 0};
    for (int k = 0; k < 11; k++) begin
      phase = $sformatf("tbl%0d", k);
      tick(tbl[k].ir, tbl[k].iw, tbl[k].dr, tbl[k].dw, tbl[k].r, tbl[k].own);
    end

    phase = "iread";
    tick(1, 0, 0, 0, 0, 0);
    repeat (3) tick(1, 0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 1, 1);
    tick(0, 0, 0, 0, 0, 0);

    phase = "dwb";
    d_dfp_addr = 32'h0000_2000;
    tick(0, 0, 0, 1, 0, 0);
    repeat (2) tick(0, 0, 0, 1, 0, 2);
    tick(0, 0, 0, 1, 1, 2);
    d_dfp_addr = 32'h0000_3000;
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 2);
    tick(0, 0, 1, 0, 1, 2);
    tick(0, 0, 0, 0, 0, 0);

    phase = "tie";
    i_dfp_addr = 32'h100; d_dfp_addr = 32'h200;
    resp_log.delete();
    for (int k = 0; k < 3; k++) begin
      tick(1, 0, 1, 0, 0, -1);
      tick(1, 0, 1, 0, 0, -1);
      w = own;
      tick(1, 0, 1, 0, 1, -1);
      tick(w == 2, 0, w == 1, 0, 0, -1);
      tick(w == 2, 0, w == 1, 0, 0, -1);
      tick(w == 2, 0, w == 1, 0, 1, -1);
    end
    tick(0, 0, 0, 0, 0, -1);
    chk("tie:count", resp_log.size(), 6);
    for (int k = 0; k < 6; k++) chk($sformatf("tie:order%0d", k), resp_log[k], exp_order[k]);

    phase = "late";
    i_dfp_addr = IA; d_dfp_addr = DA;
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 1);
    repeat (4) tick(1, 0, 1, 0, 0, 1);
    tick(1, 0, 1, 0, 1, 1);
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 2);
    tick(0, 0, 1, 0, 1, 2);
    tick(0, 0, 0, 0, 0, 0);

    phase = "rst_mid";
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 2);
    rst = 1'b1;
    @(negedge clk);
    check_outs(2);
    @(posedge clk); #1;
    rst = 1'b0;
    own = 0; last = 1;
    phase = "after_rst";
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 1, 1);
    tick(0, 0, 0, 0, 0, 0);

    phase = "rand";
    pi = 0; pd = 0; ik = 0; dk = 0;
    repeat (400) begin
      if (!pi && $urandom_range(3) == 0) begin
        pi = 1; ik = $urandom_range(2); i_dfp_addr = $urandom; i_dfp_wdata = rand_line();
      end
      if (!pd && $urandom_range(3) == 0) begin
        pd = 1; dk = $urandom_range(2); d_dfp_addr = $urandom; d_dfp_wdata = rand_line();
      end
      dfp_rdata = rand_line();
      r = own != 0 ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
      o = own;
      tick(pi && ik != 1, pi && ik != 0, pd && dk != 1, pd && dk != 0, r, -1);
      if (r && o == 1) pi = 0;
      if (r && o == 2) pd = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
